// File: rtl/control_barrido_7seg.sv
// -----------------------------------------------------------------------------
// control_barrido_7seg
//   Multiplexed 7-segment scan controller. Each enabled digit gets a slot of
//   DIV_REFRESH clock cycles: BLANK_CYCLES cycles with every anode off (this
//   hides ghosting while the downstream segment mux settles on the new digit),
//   then the remaining cycles with only that digit's anode driven low.
//
// Ports
//   clk              in   sole clock, rising edge
//   reset            in   synchronous active-high reset
//   habilitar        in   scan enable; low parks the controller in IDLE
//   digitos_activos  in   [3:0] per-digit enable mask, bit i enables digit i
//   seleccion        out  [1:0] index of the digit in the current slot
//   anodos           out  [3:0] active-low anode drives
//   barrido_completo out  one-cycle pulse after the slot that closes a scan
//   estado_o         out  [1:0] FSM state for observation (0 IDLE, 1 BLANK,
//                         2 SHOW)
//
// All outputs come straight from flops; the next-state logic computes the
// next output values so there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module control_barrido_7seg #(
   parameter int unsigned DIV_REFRESH  = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       habilitar,
   input  logic [3:0] digitos_activos,
   output logic [1:0] seleccion,
   output logic [3:0] anodos,
   output logic       barrido_completo,
   output logic [1:0] estado_o
);

   localparam int unsigned CW = (DIV_REFRESH > 2) ? $clog2(DIV_REFRESH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } estado_t;

   estado_t         estado_q, estado_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      sel_q, sel_d;
   logic [3:0]      anodos_q, anodos_d;
   logic            pulso_q, pulso_d;

   // Lowest set bit of the mask (mask assumed non-zero by the caller).
   function automatic logic [1:0] digito_menor(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (m[k]) r = 2'(k);
      end
      return r;
   endfunction

   // Next set bit strictly above cur, wrapping 3->0. Searching four steps
   // means a single-digit mask comes back to cur itself.
   function automatic logic [1:0] digito_siguiente(input logic [1:0] cur,
                                                   input logic [3:0] m);
      logic [1:0] r;
      logic [1:0] idx;
      logic       hallado;
      r       = cur;
      hallado = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = cur + 2'(k);
         if (!hallado && m[idx]) begin
            r       = idx;
            hallado = 1'b1;
         end
      end
      return r;
   endfunction

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      anodos_d = 4'b1111;
      pulso_d  = 1'b0;

      if (!habilitar) begin
         // Disable wins over everything except reset; selection is held.
         estado_d = IDLE;
         cnt_d    = '0;
      end else begin
         unique case (estado_q)
            IDLE: begin
               cnt_d = '0;
               if (digitos_activos != 4'b0000) begin
                  estado_d = BLANK;
                  sel_d    = digito_menor(digitos_activos);
               end
            end

            BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                  estado_d = SHOW;
                  anodos_d = ~(4'b0001 << sel_q);
               end
            end

            SHOW: begin
               if (cnt_q == CW'(DIV_REFRESH - 1)) begin
                  // Slot end: the only point besides IDLE where the mask
                  // is looked at, so mid-slot changes never cut a slot.
                  cnt_d = '0;
                  if (digitos_activos == 4'b0000) begin
                     estado_d = IDLE;
                  end else begin
                     estado_d = BLANK;
                     sel_d    = digito_siguiente(sel_q, digitos_activos);
                     pulso_d  = (digito_siguiente(sel_q, digitos_activos)
                                 <= sel_q);
                  end
               end else begin
                  cnt_d    = cnt_q + 1'b1;
                  anodos_d = ~(4'b0001 << sel_q);
               end
            end

            default: begin
               estado_d = IDLE;
               cnt_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= IDLE;
         cnt_q    <= '0;
         sel_q    <= 2'd0;
         anodos_q <= 4'b1111;
         pulso_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         anodos_q <= anodos_d;
         pulso_q  <= pulso_d;
      end
   end

   assign seleccion        = sel_q;
   assign anodos           = anodos_q;
   assign barrido_completo = pulso_q;
   assign estado_o         = estado_q;

endmodule

// File: tb/tb_control_barrido_7seg.sv
module tb_control_barrido_7seg;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset;
  logic       habilitar;
  logic [3:0] digitos_activos;
  logic [1:0] seleccion;
  logic [3:0] anodos;
  logic       barrido_completo;
  logic [1:0] estado_o;

  always #5 clk = ~clk;

  control_barrido_7seg #(
    .DIV_REFRESH  (DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .habilitar        (habilitar),
    .digitos_activos  (digitos_activos),
    .seleccion        (seleccion),
    .anodos           (anodos),
    .barrido_completo (barrido_completo),
    .estado_o         (estado_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: advance one clock; inputs set afterwards land on the next edge,
  // outputs read afterwards are the values registered on this edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [1:0] exp_sel);
    check_val({tag, " estado"}, 32'(estado_o), 32'(ST_IDLE));
    check_val({tag, " anodos"}, 32'(anodos), 32'hF);
    check_val({tag, " sel"}, 32'(seleccion), 32'(exp_sel));
    check_val({tag, " pulso"}, 32'(barrido_completo), 32'h0);
  endtask

  // Check ncyc cycles of a slot starting on its first BLANK cycle.
  // Cycles 0..BLANK-1 dark, the rest show digit exp_sel; the wrap pulse only
  // on cycle 0. After the check of cycle chg_c the mask is changed.
  task automatic check_slot(input logic [1:0] exp_sel, input logic exp_pulse,
                            input int ncyc, input int chg_c,
                            input logic [3:0] chg_mask);
    logic [3:0] exp_an;
    for (int c = 0; c < ncyc; c++) begin
      exp_an = (c < BLANK) ? 4'hF : (4'hF ^ (4'b0001 << exp_sel));
      check_val($sformatf("slot%0d c%0d sel", exp_sel, c), 32'(seleccion), 32'(exp_sel));
      check_val($sformatf("slot%0d c%0d anodos", exp_sel, c), 32'(anodos), 32'(exp_an));
      check_val($sformatf("slot%0d c%0d pulso", exp_sel, c), 32'(barrido_completo),
                32'((c == 0) ? exp_pulse : 1'b0));
      check_val($sformatf("slot%0d c%0d estado", exp_sel, c), 32'(estado_o),
                32'((c < BLANK) ? ST_BLANK : ST_SHOW));
      if (c == chg_c) digitos_activos = chg_mask;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; habilitar = 1'b0; digitos_activos = 4'h0;
    step(); step();
    check_idle("reset", 2'd0);

    // full mask: 0,1,2,3 then wrap to 0 with the pulse
    reset = 1'b0; habilitar = 1'b1; digitos_activos = 4'hF;
    step();
    check_slot(2'd0, 1'b0, DIV, -1, 4'h0);
    check_slot(2'd1, 1'b0, DIV, -1, 4'h0);
    check_slot(2'd2, 1'b0, DIV, -1, 4'h0);
    check_slot(2'd3, 1'b0, DIV, -1, 4'h0);
    check_slot(2'd0, 1'b1, DIV, -1, 4'h0);

    // mask 1111 -> 1000 during SHOW of digit 1: slot still full length
    check_slot(2'd1, 1'b0, DIV, 4, 4'h8);
    check_slot(2'd3, 1'b0, DIV, -1, 4'h0);
    check_slot(2'd3, 1'b1, DIV, -1, 4'h0);
    // switch to 0101 inside digit 3's slot
    check_slot(2'd3, 1'b1, DIV, 5, 4'h5);
    check_slot(2'd0, 1'b1, DIV, -1, 4'h0);
    check_slot(2'd2, 1'b0, DIV, -1, 4'h0);
    check_slot(2'd0, 1'b1, DIV, -1, 4'h0);

    // drop habilitar during SHOW of digit 2
    check_slot(2'd2, 1'b0, 5, -1, 4'h0);
    habilitar = 1'b0;
    step();
    check_idle("disable", 2'd2);
    step();
    check_idle("disable hold", 2'd2);
    habilitar = 1'b1;
    step();
    check_slot(2'd0, 1'b0, DIV, -1, 4'h0);

    // reset during SHOW of digit 2
    check_slot(2'd2, 1'b0, 5, -1, 4'h0);
    reset = 1'b1;
    step();
    check_idle("mid reset", 2'd0);

    // empty mask with scan enabled: stays idle
    reset = 1'b0; digitos_activos = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle($sformatf("empty%0d", i), 2'd0);
    end
    digitos_activos = 4'h8;
    step();
    check_slot(2'd3, 1'b0, DIV, -1, 4'h0);
    check_slot(2'd3, 1'b1, DIV, 5, 4'h0);
    // mask went to 0 at slot end: IDLE, selection held
    check_idle("mask0 end", 2'd3);

    // reset together with habilitar low: reset wins (selection cleared)
    digitos_activos = 4'hF; habilitar = 1'b0; reset = 1'b1;
    step();
    check_idle("reset+dis", 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_barrido_7seg.md
CONTROL_BARRIDO_7SEG -- requirements
Module: control_barrido_7seg

Interface
REQ-001 SHALL have parameter DIV_REFRESH, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, blanking cycles at the start of each slot; legal range 1..DIV_REFRESH-1.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port habilitar, input, 1, scan enable.
REQ-006 SHALL have port digitos_activos, input, 4, per-digit enable mask; bit i enables digit i.
REQ-007 SHALL have port seleccion, output, 2, index of the digit being shown; feeds the downstream message multiplexer select.
REQ-008 SHALL have port anodos, output, 4, active-low digit anode drives.
REQ-009 SHALL have port barrido_completo, output, 1, one-cycle pulse at the end of each full scan.

Function
REQ-010 SHALL implement FSM states IDLE, BLANK and SHOW, with a slot counter cnt of width ceil(log2(DIV_REFRESH)).
REQ-011 SHALL drive every output from registers only, with no combinational path from any input to any output.
REQ-012 IDLE: when habilitar=1 and digitos_activos!=0, next cycle SHALL be BLANK, with seleccion = lowest set mask bit and cnt=0; otherwise SHALL stay in IDLE.
REQ-013 BLANK: cnt SHALL increment each cycle; when cnt==BLANK_CYCLES-1, next cycle SHALL be SHOW with cnt continuing to BLANK_CYCLES.
REQ-014 SHOW: cnt SHALL increment each cycle; when cnt==DIV_REFRESH-1, next cycle SHALL be BLANK with cnt=0 and seleccion = next set mask bit above the current index, wrapping 3->0.
REQ-015 One slot SHALL therefore last exactly DIV_REFRESH cycles: BLANK_CYCLES cycles blank, then DIV_REFRESH-BLANK_CYCLES cycles shown.
REQ-016 anodos SHALL be 4'b1111 in IDLE and BLANK; in SHOW, only bit [seleccion] SHALL be 0.
REQ-017 seleccion SHALL change only on entry to BLANK, so it is stable for the whole slot, including the blank phase.
REQ-018 digitos_activos SHALL be sampled only at slot end (REQ-014) and in IDLE (REQ-012); a mid-slot mask change SHALL NOT shorten or alter the current slot.
REQ-019 If the mask sampled at slot end is 0, the FSM SHALL go to IDLE, with anodos=1111 and seleccion unchanged.
REQ-020 With a single active digit, seleccion SHALL stay on that digit and repeat BLANK/SHOW slots.
REQ-021 barrido_completo SHALL be 1 for exactly the cycle after a SHOW slot ends whose next digit index is <= the current index (wrap), including the single-digit case; it SHALL be 0 otherwise.
REQ-022 habilitar=0 in any state SHALL force IDLE next cycle, with cnt=0, anodos=1111, barrido_completo=0 and seleccion held.
REQ-023 On re-enable, scanning SHALL restart per REQ-012 from the lowest active digit.
REQ-024 If reset and habilitar=0 occur together, reset SHALL take precedence.

Reset
REQ-025 With reset=1 at a rising edge, next cycle SHALL give state=IDLE, cnt=0, seleccion=2'd0, anodos=4'b1111, barrido_completo=0, regardless of state, including mid-slot.
REQ-026 After reset deasserts, operation SHALL follow REQ-012: first BLANK no earlier than one cycle after reset falls.
REQ-027 No output SHALL glitch low on anodos during or immediately after reset.

Verification (DIV_REFRESH=8, BLANK_CYCLES=2)
REQ-028 Reset, then habilitar=1, mask=1111 -> seleccion sequence 0,1,2,3,0, each held 8 cycles; per slot anodos 1111 x2 then 1110/1101/1011/0111 x6; barrido_completo high once every 32 cycles, at the 3->0 wrap.
REQ-029 mask=0101 -> seleccion sequence 0,2,0,2; digits 1 and 3 never driven low; barrido_completo high every 16 cycles.
REQ-030 mask=0000 with habilitar=1 -> anodos=1111 and seleccion=0 indefinitely; no pulses; setting mask=1000 -> BLANK next cycle with seleccion=3.
REQ-031 Mask changed 1111 -> 1000 during the SHOW of digit 1 -> digit 1 slot completes the full 8 cycles, next seleccion=3, then 3 repeats with a pulse every 8 cycles.
REQ-032 habilitar dropped during the SHOW of digit 2 -> anodos=1111 the next cycle; on re-enable, BLANK one cycle later with seleccion=0.
REQ-033 reset pulsed during the SHOW of digit 2 -> next cycle seleccion=0, anodos=1111, barrido_completo=0, state IDLE.
